// File: rtl/wb_pkg.sv
// Shared encodings for the write-back select stage: source select, load type
// and the two-state memory-wait controller.
package wb_pkg;

  typedef enum logic [2:0] {
    SEL_ALU  = 3'b000,
    SEL_LINK = 3'b001,
    SEL_LOAD = 3'b010,
    SEL_CP0  = 3'b011,
    SEL_HI   = 3'b100,
    SEL_LO   = 3'b101
  } sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_H  = 3'b001,
    LD_HU = 3'b010,
    LD_B  = 3'b011,
    LD_BU = 3'b100
  } ld_type_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

endpackage

// File: rtl/wb_select_stage_load_align.sv
// Little-endian load data alignment with sign/zero extension to DATA_W.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        ld_type,
  input  logic [OFF_W-1:0]  ld_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_word;
  logic [OFF_W-1:0] w_half_off;

  // Halfword offsets are forced even; bit 0 of the address is ignored.
  assign w_half_off = {ld_off[OFF_W-1:1], 1'b0};
  assign w_byte     = rdata[8*ld_off +: 8];
  assign w_half     = rdata[8*w_half_off +: 16];

  if (DATA_W == 64) begin : g_word64
    assign w_word = rdata[32*ld_off[OFF_W-1] +: 32];
  end else begin : g_word32
    assign w_word = rdata[31:0];
  end

  always_comb begin
    case (ld_type_e'(ld_type))
      LD_H:    data = DATA_W'(signed'(w_half));
      LD_HU:   data = DATA_W'(w_half);
      LD_B:    data = DATA_W'(signed'(w_byte));
      LD_BU:   data = DATA_W'(w_byte);
      default: data = DATA_W'(signed'(w_word));
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// Write-back source select: picks the result for the register file and holds
// a single outstanding load until the data memory answers.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_OFF = 8,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_sel,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] alu_r,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] cp0_d,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [2:0]        ld_type,
  input  logic [OFF_W-1:0]  ld_off,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  state_e            r_state, w_state_nxt;
  logic              r_ld_wen;
  logic [ADDR_W-1:0] r_ld_waddr;
  logic [2:0]        r_ld_type;
  logic [OFF_W-1:0]  r_ld_off;

  logic              w_wait, w_xfer, w_is_load, w_latch;
  logic              w_do_write, w_wr_wen;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data, w_sel_data, w_aligned;
  logic [2:0]        w_al_type;
  logic [OFF_W-1:0]  w_al_off;

  assign w_wait    = (r_state == ST_WAIT_MEM);
  assign busy      = w_wait;
  assign in_ready  = !w_wait || dm_rvalid;
  assign w_xfer    = in_valid && in_ready;
  assign w_is_load = (sel_e'(in_sel) == SEL_LOAD);

  // A pending load aligns with its latched fields; otherwise use the live ones.
  assign w_al_type = w_wait ? r_ld_type : ld_type;
  assign w_al_off  = w_wait ? r_ld_off  : ld_off;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .ld_type (w_al_type),
    .ld_off  (w_al_off),
    .rdata   (dm_rdata),
    .data    (w_aligned)
  );

  always_comb begin
    case (sel_e'(in_sel))
      SEL_ALU:  w_sel_data = alu_r;
      SEL_LINK: w_sel_data = pc + DATA_W'(LINK_OFF);
      SEL_LOAD: w_sel_data = w_aligned;
      SEL_CP0:  w_sel_data = cp0_d;
      SEL_HI:   w_sel_data = hi;
      SEL_LO:   w_sel_data = lo;
      default:  w_sel_data = '0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_do_write  = 1'b0;
    w_wr_wen    = 1'b0;
    w_wr_addr   = in_waddr;
    w_wr_data   = w_sel_data;
    w_latch     = 1'b0;
    if (w_wait) begin
      // The returning load owns the write port; dm_rvalid belongs to it, so a
      // load accepted alongside it must wait for its own response.
      if (dm_rvalid) begin
        w_do_write  = 1'b1;
        w_wr_wen    = r_ld_wen;
        w_wr_addr   = r_ld_waddr;
        w_wr_data   = w_aligned;
        w_state_nxt = ST_IDLE;
      end
      if (w_xfer && w_is_load) begin
        w_latch     = 1'b1;
        w_state_nxt = ST_WAIT_MEM;
      end
    end else if (w_xfer) begin
      if (w_is_load && !dm_rvalid) begin
        w_latch     = 1'b1;
        w_state_nxt = ST_WAIT_MEM;
      end else begin
        w_do_write = 1'b1;
        w_wr_wen   = in_wen;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_ld_wen   <= 1'b0;
      r_ld_waddr <= '0;
      r_ld_type  <= '0;
      r_ld_off   <= '0;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      rf_wen  <= w_do_write && w_wr_wen && (w_wr_addr != '0);
      if (w_do_write) begin
        rf_waddr <= w_wr_addr;
        rf_wdata <= w_wr_data;
      end
      if (w_latch) begin
        r_ld_wen   <= in_wen;
        r_ld_waddr <= in_waddr;
        r_ld_type  <= ld_type;
        r_ld_off   <= ld_off;
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed scenarios plus random
// traffic compared against a transaction-level model of the write-back stage.
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_sel, ld_type;
  logic [4:0]  in_waddr, rf_waddr;
  logic [31:0] alu_r, pc, cp0_d, hi, lo, dm_rdata, rf_wdata;
  logic [1:0]  ld_off;
  logic        dm_rvalid, rf_wen, busy;

  int checks = 0;
  int errors = 0;

  // Model: at most one outstanding load plus the expected register-file port.
  bit          m_pend;
  logic        m_p_wen;
  logic [4:0]  m_p_addr;
  logic [2:0]  m_p_type;
  logic [1:0]  m_p_off;
  logic        e_wen;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  always #5 clk = ~clk;

  wb_select_stage dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_wen(in_wen), .in_waddr(in_waddr),
    .alu_r(alu_r), .pc(pc), .cp0_d(cp0_d), .hi(hi), .lo(lo),
    .ld_type(ld_type), .ld_off(ld_off), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(logic [2:0] t, logic [1:0] off, logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'h0000_00FF;
    h = (d >> (16 * off[1])) & 32'h0000_FFFF;
    case (t)
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] src_val(logic [2:0] s);
    case (s)
      3'd0:    return alu_r;
      3'd1:    return pc + 32'd8;
      3'd3:    return cp0_d;
      3'd4:    return hi;
      3'd5:    return lo;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_p_wen = 0; m_p_addr = 0; m_p_type = 0; m_p_off = 0;
    e_wen = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step(bit ready);
    bit was, xfer, wr;
    logic ww;
    logic [4:0] wa;
    logic [31:0] wd;
    was = m_pend; xfer = in_valid && ready; wr = 0; ww = 0; wa = 0; wd = 0;
    if (was && dm_rvalid) begin
      wr = 1; ww = m_p_wen; wa = m_p_addr; wd = ref_align(m_p_type, m_p_off, dm_rdata);
      m_pend = 0;
    end
    if (xfer) begin
      if (in_sel == 3'd2) begin
        if (!was && dm_rvalid) begin
          wr = 1; ww = in_wen; wa = in_waddr; wd = ref_align(ld_type, ld_off, dm_rdata);
        end else begin
          m_pend = 1; m_p_wen = in_wen; m_p_addr = in_waddr; m_p_type = ld_type; m_p_off = ld_off;
        end
      end else if (!was) begin
        wr = 1; ww = in_wen; wa = in_waddr; wd = src_val(in_sel);
      end
    end
    if (wr) begin
      e_wen = ww && (wa != 0); e_addr = wa; e_data = wd;
    end else begin
      e_wen = 0;
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    bit exp_ready;
    #1;
    exp_ready = !m_pend || dm_rvalid;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_pend));
    model_step(exp_ready);
    @(posedge clk); #1;
    chk("rf_wen", 32'(rf_wen), 32'(e_wen));
    chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
    chk("rf_wdata", rf_wdata, e_data);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_sel = 0; in_wen = 0; in_waddr = 0; ld_type = 0; ld_off = 0;
    dm_rvalid = 0; dm_rdata = 0;
  endtask

  task automatic slow_load(logic [2:0] t, logic [31:0] exp);
    in_valid = 1; in_sel = 3'd2; in_wen = 1; in_waddr = 5'd9; ld_type = t; ld_off = 2'd2;
    dm_rvalid = 0;
    cycle();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wait_ready_low", 32'(in_ready), 32'd0);
      chk("wait_busy_high", 32'(busy), 32'd1);
    end
    dm_rvalid = 1; dm_rdata = 32'h0080_0000;
    cycle();
    chk("slow_load_wdata", rf_wdata, exp);
    chk("slow_load_wen", 32'(rf_wen), 32'd1);
    dm_rvalid = 0;
  endtask

  task automatic fast_load(logic [2:0] t, logic [31:0] exp);
    in_valid = 1; in_sel = 3'd2; in_wen = 1; in_waddr = 5'd10; ld_type = t; ld_off = 2'd2;
    dm_rvalid = 1; dm_rdata = 32'h8001_0000;
    cycle();
    chk("fast_load_busy", 32'(busy), 32'd0);
    chk("fast_load_wdata", rf_wdata, exp);
    idle_inputs();
  endtask

  initial begin
    alu_r = 0; pc = 0; cp0_d = 32'hC0C0_0001; hi = 32'h4949_0002; lo = 32'h1010_0003;
    idle_inputs();
    model_reset();
    resetn = 0;
    repeat (2) @(negedge clk);
    chk("reset_wen", 32'(rf_wen), 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    resetn = 1;

    // ALU write with one-cycle latency and a single-cycle rf_wen pulse.
    in_valid = 1; in_sel = 3'd0; in_wen = 1; in_waddr = 5'd3; alu_r = 32'h1234_5678;
    cycle();
    chk("alu_wen", 32'(rf_wen), 32'd1);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    in_valid = 0;
    cycle();
    chk("alu_wen_drop", 32'(rf_wen), 32'd0);

    // Link writes, including wrap-around.
    in_valid = 1; in_sel = 3'd1; in_waddr = 5'd31; pc = 32'hBFC0_0000;
    cycle();
    chk("link_wdata", rf_wdata, 32'hBFC0_0008);
    pc = 32'hFFFF_FFFC;
    cycle();
    chk("link_wrap", rf_wdata, 32'h0000_0004);
    idle_inputs();

    slow_load(3'd3, 32'hFFFF_FF80);
    slow_load(3'd4, 32'h0000_0080);
    fast_load(3'd1, 32'hFFFF_8001);
    fast_load(3'd2, 32'h0000_8001);

    // Writes to register zero never assert rf_wen; unused selects give zero.
    in_valid = 1; in_sel = 3'd0; in_wen = 1; in_waddr = 5'd0; alu_r = 32'hDEAD_BEEF;
    cycle();
    chk("zero_reg_wen", 32'(rf_wen), 32'd0);
    in_sel = 3'd6; in_waddr = 5'd4;
    cycle();
    chk("sel_other_zero", rf_wdata, 32'd0);
    idle_inputs();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_wen    = ($urandom_range(0, 5) != 0);
      in_waddr  = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
      ld_type   = 3'($urandom_range(0, 7));
      ld_off    = 2'($urandom_range(0, 3));
      dm_rvalid = ($urandom_range(0, 2) == 0);
      dm_rdata  = $urandom;
      alu_r = $urandom; pc = $urandom; cp0_d = $urandom; hi = $urandom; lo = $urandom;
      // Only a load may be accepted in the cycle that completes a pending load.
      if (m_pend && dm_rvalid && in_valid && in_sel != 3'd2) in_valid = 0;
      cycle();
    end
    idle_inputs();

    // Reset while a load is pending; the late response must be ignored.
    in_valid = 1; in_sel = 3'd2; in_wen = 1; in_waddr = 5'd12; ld_type = 3'd0; dm_rvalid = 0;
    cycle();
    idle_inputs();
    #2 resetn = 0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_wen", 32'(rf_wen), 32'd0);
    chk("async_rst_waddr", 32'(rf_waddr), 32'd0);
    chk("async_rst_wdata", rf_wdata, 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1;
    dm_rvalid = 1; dm_rdata = 32'h5555_AAAA;
    cycle();
    chk("stray_rvalid_wen", 32'(rf_wen), 32'd0);
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
